// File: rtl/mips_cpu_harvard_tb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_harvard_tb_pkg
//  Description : Shared types for the mips_cpu_harvard run controller:
//                controller state encoding and the reported status codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_cpu_harvard_tb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RESET = 3'd1,
        CHECK = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ST_NONE    = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } status_t;

    localparam int c_count_w = 32;

    // States in which the CPU is clocked and a run is in progress
    function automatic logic is_busy(input state_t s);
        return (s == RESET) || (s == CHECK) || (s == RUN) || (s == DRAIN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_cpu_harvard_cycle_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_harvard_cycle_counter
//  Description : Saturating 32-bit cycle counter with synchronous clear and a
//                terminal-count flag raised when the count is TIMEOUT_CYCLES-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_harvard_cycle_counter
    import mips_cpu_harvard_tb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_enable,
    output logic [c_count_w-1:0] o_count,
    output logic                 o_terminal
);

    localparam logic [c_count_w-1:0] c_terminal = c_count_w'(TIMEOUT_CYCLES - 1);

    logic [c_count_w-1:0] r_count;

    // Count enabled cycles, holding at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count    = r_count;
    assign o_terminal = (r_count == c_terminal);

endmodule
`default_nettype wire

// File: rtl/mips_cpu_harvard_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_harvard_run_ctrl
//  Description : Run controller for a mips_cpu_harvard instance. Sequences the
//                CPU reset, confirms active rises, times the run to halt or
//                timeout, captures register_v0 and reports a status word.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_harvard_run_ctrl
    import mips_cpu_harvard_tb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100,
    parameter int unsigned RESET_CYCLES   = 1,
    parameter bit          CHECK_V0       = 1'b1,
    parameter logic [31:0] EXPECTED_V0    = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        cpu_reset,
    output logic        cpu_clk_enable,
    input  logic        cpu_active,
    input  logic [31:0] cpu_register_v0,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status,
    output logic [31:0] result_v0,
    output logic [31:0] cycle_count
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("mips_cpu_harvard_run_ctrl: TIMEOUT_CYCLES must be >= 2");
    end

    if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
        $error("mips_cpu_harvard_run_ctrl: RESET_CYCLES must be >= 1");
    end

    localparam int c_rst_w = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [c_rst_w-1:0] c_rst_last = c_rst_w'(RESET_CYCLES - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_start_ok;
    logic [c_rst_w-1:0]   r_rst_cnt;
    logic                 r_cpu_reset;
    logic                 r_cpu_clk_enable;
    logic                 r_busy;
    logic                 r_done;
    status_t              r_status;
    logic [31:0]          r_result_v0;
    logic [c_count_w-1:0] w_count;
    logic                 w_terminal;
    logic                 w_count_en;
    logic                 w_v0_ok;

    // The release cycle counts, so CHECK contributes when the CPU is active
    assign w_count_en = ((r_state == CHECK) || (r_state == RUN)) && cpu_active;
    assign w_v0_ok    = !CHECK_V0 || (cpu_register_v0 == EXPECTED_V0);

    mips_cpu_harvard_cycle_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_cycle_counter (
        .clk        (clk),
        .rst        (reset),
        .i_clear    (w_start_ok),
        .i_enable   (w_count_en),
        .o_count    (w_count),
        .o_terminal (w_terminal)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; a halt seen on the terminal cycle takes priority
    always_comb begin
        w_state_next = r_state;
        w_start_ok   = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_next = RESET;
                    w_start_ok   = 1'b1;
                end
            end
            RESET: begin
                if (r_rst_cnt == c_rst_last) begin
                    w_state_next = CHECK;
                end
            end
            CHECK: begin
                w_state_next = cpu_active ? RUN : DONE;
            end
            RUN: begin
                if (!cpu_active) begin
                    w_state_next = DRAIN;
                end else if (w_terminal) begin
                    w_state_next = DONE;
                end
            end
            DRAIN: begin
                w_state_next = DONE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Counts the cycles spent holding the CPU in reset
    always_ff @(posedge clk) begin
        if (reset || (r_state != RESET)) begin
            r_rst_cnt <= '0;
        end else begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
        end
    end

    // Registered CPU controls and handshake flags, decoded from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_reset      <= 1'b1;
            r_cpu_clk_enable <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
        end else begin
            r_cpu_reset      <= (w_state_next == IDLE) || (w_state_next == RESET);
            r_cpu_clk_enable <= is_busy(w_state_next);
            r_busy           <= is_busy(w_state_next);
            r_done           <= (w_state_next == DONE);
        end
    end

    // Run outcome: cleared on a new run, set on failure, timeout or drain end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_status    <= ST_NONE;
            r_result_v0 <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_status    <= ST_NONE;
                        r_result_v0 <= '0;
                    end
                end
                CHECK: begin
                    if (!cpu_active) begin
                        r_status <= ST_FAIL;
                    end
                end
                RUN: begin
                    if (cpu_active && w_terminal) begin
                        r_status <= ST_TIMEOUT;
                    end
                end
                DRAIN: begin
                    r_result_v0 <= cpu_register_v0;
                    r_status    <= w_v0_ok ? ST_PASS : ST_FAIL;
                end
                default: begin
                    r_status <= r_status;
                end
            endcase
        end
    end

    assign cpu_reset      = r_cpu_reset;
    assign cpu_clk_enable = r_cpu_clk_enable;
    assign busy           = r_busy;
    assign done           = r_done;
    assign status         = r_status;
    assign result_v0      = r_result_v0;
    assign cycle_count    = w_count;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_harvard_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_cpu_harvard_run_ctrl
//  Description : Bench for the run controller. Two controllers with different
//                parameters each drive a behavioural CPU stub whose halt cycle
//                and final v0 are programmable; outputs are compared every
//                cycle against a run-timeline model of the controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_harvard_run_ctrl;

    localparam int NI    = 2;
    localparam int NEVER = 1000000;

    // Instance 0: long timeout, 2 reset cycles, v0 checked against 5
    // Instance 1: short timeout, 1 reset cycle, v0 not checked
    int          p_r   [NI] = '{2, 1};
    int          p_t   [NI] = '{100, 20};
    bit          p_chk [NI] = '{1'b1, 1'b0};
    logic [31:0] p_exp [NI] = '{32'd5, 32'd5};

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;

    logic        cpu_reset   [NI];
    logic        cpu_en      [NI];
    logic        cpu_active  [NI];
    logic [31:0] cpu_v0      [NI];
    logic        busy        [NI];
    logic        done        [NI];
    logic [1:0]  status      [NI];
    logic [31:0] result_v0   [NI];
    logic [31:0] cycle_count [NI];

    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 1'b0;

    always #5 clk = ~clk;

    mips_cpu_harvard_run_ctrl #(
        .TIMEOUT_CYCLES (100),
        .RESET_CYCLES   (2),
        .CHECK_V0       (1'b1),
        .EXPECTED_V0    (32'd5)
    ) dut_a (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .cpu_reset       (cpu_reset[0]),
        .cpu_clk_enable  (cpu_en[0]),
        .cpu_active      (cpu_active[0]),
        .cpu_register_v0 (cpu_v0[0]),
        .busy            (busy[0]),
        .done            (done[0]),
        .status          (status[0]),
        .result_v0       (result_v0[0]),
        .cycle_count     (cycle_count[0])
    );

    mips_cpu_harvard_run_ctrl #(
        .TIMEOUT_CYCLES (20),
        .RESET_CYCLES   (1),
        .CHECK_V0       (1'b0),
        .EXPECTED_V0    (32'd5)
    ) dut_b (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .cpu_reset       (cpu_reset[1]),
        .cpu_clk_enable  (cpu_en[1]),
        .cpu_active      (cpu_active[1]),
        .cpu_register_v0 (cpu_v0[1]),
        .busy            (busy[1]),
        .done            (done[1]),
        .status          (status[1]),
        .result_v0       (result_v0[1]),
        .cycle_count     (cycle_count[1])
    );

    // ---------------- CPU stub ----------------
    // rel = enabled cycles since reset release; active drops at rel == halt,
    // v0 reads as a moving value until after the halt, then the programmed value.
    int          halt_cfg [NI] = '{NEVER, NEVER};
    logic [31:0] v0_cfg   [NI] = '{32'd0, 32'd0};
    int          rel      [NI] = '{0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (cpu_reset[i] === 1'b1) rel[i] <= 0;
            else if (cpu_en[i] === 1'b1 && rel[i] < NEVER) rel[i] <= rel[i] + 1;
        end
    end

    always_comb begin
        for (int i = 0; i < NI; i++) begin
            cpu_active[i] = (rel[i] < halt_cfg[i]);
            cpu_v0[i]     = (rel[i] > halt_cfg[i]) ? v0_cfg[i] : (32'hA000_0000 | 32'(rel[i]));
        end
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        cpu_reset;
        logic        en;
        logic        busy;
        logic        done;
        logic [1:0]  status;
        logic [31:0] result;
        logic [31:0] count;
    } exp_t;

    int          m_age [NI] = '{-1, -1};   // clock edges since start accepted, -1 = idle
    int          m_h   [NI] = '{0, 0};
    logic [31:0] m_v   [NI] = '{32'd0, 32'd0};

    // Expected outputs from the run timeline: R reset cycles, then the release
    // cycle c=0; the run ends by check failure, halt+drain or timeout.
    function automatic exp_t model_out(input int i);
        exp_t        e;
        int          c, f, fin_c;
        logic [1:0]  st;
        logic [31:0] res;
        e = '0;
        e.cpu_reset = 1'b1;
        if (m_age[i] < 0) return e;
        if (m_age[i] <= p_r[i]) begin
            e.en   = 1'b1;
            e.busy = 1'b1;
            return e;
        end
        c = m_age[i] - p_r[i] - 1;
        if (m_h[i] == 0) begin
            f = 0; fin_c = 1; st = 2'd2; res = 32'd0;
        end else if (m_h[i] < p_t[i]) begin
            f = m_h[i]; fin_c = m_h[i] + 2;
            st = (!p_chk[i] || m_v[i] == p_exp[i]) ? 2'd1 : 2'd2;
            res = m_v[i];
        end else begin
            f = p_t[i]; fin_c = p_t[i]; st = 2'd3; res = 32'd0;
        end
        e.cpu_reset = 1'b0;
        if (c < fin_c) begin
            e.en    = 1'b1;
            e.busy  = 1'b1;
            e.count = 32'((c < f) ? c : f);
        end else begin
            e.done   = 1'b1;
            e.status = st;
            e.result = res;
            e.count  = 32'(f);
        end
        return e;
    endfunction

    function automatic logic model_busy(input int i);
        exp_t e;
        e = model_out(i);
        return e.busy;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                m_age[i] <= -1;
            end else if (start && !model_busy(i)) begin
                m_age[i] <= 1;
                m_h[i]   <= halt_cfg[i];
                m_v[i]   <= v0_cfg[i];
            end else if (m_age[i] >= 0 && m_age[i] < NEVER) begin
                m_age[i] <= m_age[i] + 1;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic cmp_cycle();
        for (int i = 0; i < NI; i++) begin
            exp_t e, a;
            e = model_out(i);
            a.cpu_reset = cpu_reset[i];
            a.en        = cpu_en[i];
            a.busy      = busy[i];
            a.done      = done[i];
            a.status    = status[i];
            a.result    = result_v0[i];
            a.count     = cycle_count[i];
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_cmp[%0d] @%0t got rst=%b en=%b busy=%b done=%b st=%0d res=%h cnt=%0d, expected rst=%b en=%b busy=%b done=%b st=%0d res=%h cnt=%0d",
                         i, $time, a.cpu_reset, a.en, a.busy, a.done, a.status, a.result, a.count,
                         e.cpu_reset, e.en, e.busy, e.done, e.status, e.result, e.count);
            end
        end
    endtask

    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Advance one cycle; outputs are compared at the falling edge
    task automatic tick();
        @(negedge clk);
        if (chk_en) cmp_cycle();
    endtask

    // One run on both controllers; abort_at>0 applies reset after that many cycles
    task automatic do_run(input int ha, input logic [31:0] va, input int hb, input logic [31:0] vb,
                          input bit noise, input int abort_at);
        int k;
        halt_cfg[0] = ha; v0_cfg[0] = va;
        halt_cfg[1] = hb; v0_cfg[1] = vb;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_lit("start_accepted_busy", {31'd0, busy[0]}, 32'd1);
        k = 0;
        while (!(done[0] === 1'b1 && done[1] === 1'b1) && k < 400) begin
            if (abort_at > 0 && k == abort_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check_lit("abort_cpu_reset", {31'd0, cpu_reset[0]}, 32'd1);
                return;
            end
            start = (noise && busy[0] && busy[1] && $urandom_range(0, 7) == 0);
            tick();
            start = 1'b0;
            k++;
        end
        if (k >= 400) begin
            checks++;
            errors++;
            $display("FAIL run_wait: got done=%b/%b after 400 cycles, expected both done", done[0], done[1]);
        end
        tick();
    endtask

    function automatic int pick_h(input int t);
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return t - 1;
            2:       return t;
            3:       return NEVER;
            default: return int'($urandom_range(1, t + 5));
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        check_lit("rst_cpu_reset", {31'd0, cpu_reset[0]}, 32'd1);
        check_lit("rst_clk_en", {31'd0, cpu_en[0]}, 32'd0);
        check_lit("rst_done", {31'd0, done[0]}, 32'd0);
        check_lit("rst_status", {30'd0, status[0]}, 32'd0);
        check_lit("rst_count", cycle_count[0], 32'd0);
        tick();

        // T1: halt 10 cycles after release with the golden v0
        do_run(10, 32'd5, 10, 32'd5, 1'b0, 0);
        check_lit("t1_status", {30'd0, status[0]}, 32'd1);
        check_lit("t1_count", cycle_count[0], 32'd10);
        check_lit("t1_done", {31'd0, done[0]}, 32'd1);
        check_lit("t1_result", result_v0[0], 32'd5);

        // T2: wrong v0 fails when checked, passes when not checked
        do_run(10, 32'd7, 10, 32'd7, 1'b0, 0);
        check_lit("t2_status_chk", {30'd0, status[0]}, 32'd2);
        check_lit("t2_result", result_v0[0], 32'd7);
        check_lit("t2_status_nochk", {30'd0, status[1]}, 32'd1);

        // T3: never halts -> timeout, clock gated off
        do_run(NEVER, 32'd5, 5, 32'd9, 1'b0, 0);
        check_lit("t3_status", {30'd0, status[0]}, 32'd3);
        check_lit("t3_count", cycle_count[0], 32'd100);
        check_lit("t3_clk_en", {31'd0, cpu_en[0]}, 32'd0);

        // T4: active low at the check cycle
        do_run(0, 32'd5, 0, 32'd5, 1'b0, 0);
        check_lit("t4_status", {30'd0, status[0]}, 32'd2);
        check_lit("t4_result", result_v0[0], 32'd0);
        check_lit("t4_count", cycle_count[0], 32'd0);

        // T5: halt on the terminal cycle wins over timeout
        do_run(99, 32'd5, 19, 32'd1, 1'b0, 0);
        check_lit("t5_status", {30'd0, status[0]}, 32'd1);
        check_lit("t5_count", cycle_count[0], 32'd99);
        check_lit("t5_status_b", {30'd0, status[1]}, 32'd1);

        // T6: start during run ignored, reset mid-run, rerun from idle and from done
        halt_cfg[0] = 50; v0_cfg[0] = 32'd5;
        halt_cfg[1] = 50; v0_cfg[1] = 32'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_lit("t6_busy_after_start", {31'd0, busy[0]}, 32'd1);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_lit("t6_reset_cpu_reset", {31'd0, cpu_reset[0]}, 32'd1);
        check_lit("t6_reset_busy", {31'd0, busy[0]}, 32'd0);
        tick();
        do_run(3, 32'd5, 3, 32'd5, 1'b0, 0);
        do_run(4, 32'd5, 4, 32'd6, 1'b0, 0);
        check_lit("t6_rerun_count", cycle_count[0], 32'd4);
        check_lit("t6_rerun_status", {30'd0, status[0]}, 32'd1);

        // Randomised runs with stray start pulses and occasional aborts
        for (int n = 0; n < 30; n++) begin
            int          ha, hb, ab;
            logic [31:0] va, vb;
            ha = pick_h(100);
            hb = pick_h(20);
            va = $urandom_range(0, 1) ? 32'd5 : $urandom();
            vb = $urandom();
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 60)) : 0;
            do_run(ha, va, hb, vb, 1'b1, ab);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
